// File: rtl/sobel_stream_packer.sv
// Sobel edge-pixel packer: packs DATA_WIDTH pixels little-endian into
// OUT_WIDTH words, buffers them in a FWFT FIFO and emits AXI4-Stream.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   pixel_in[_valid]  pixel stream, no backpressure
//   m_t*              AXI4-Stream master (tdata/tkeep/tlast/tvalid/tready)
//   fifo_level        current FIFO occupancy (0..FIFO_DEPTH)
//   frame_done        one-cycle pulse after the tlast handshake
//   overflow[_clr]    sticky word-drop flag and its clear
module sobel_stream_packer #(
  parameter  int DATA_WIDTH = 8,
  parameter  int OUT_WIDTH  = 32,
  parameter  int IMG_WIDTH  = 10,
  parameter  int IMG_HEIGHT = 4,
  parameter  int FIFO_DEPTH = 16,
  localparam int PPW        = OUT_WIDTH / DATA_WIDTH,
  localparam int LVW        = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] pixel_in,
  input  logic                  pixel_in_valid,
  output logic [OUT_WIDTH-1:0]  m_tdata,
  output logic [PPW-1:0]        m_tkeep,
  output logic                  m_tlast,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic [LVW-1:0]        fifo_level,
  output logic                  frame_done,
  output logic                  overflow,
  input  logic                  overflow_clr
);

  localparam int NPIX = IMG_WIDTH * IMG_HEIGHT;
  localparam int PCW  = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int LNW  = (PPW > 1) ? $clog2(PPW) : 1;
  localparam int AW   = $clog2(FIFO_DEPTH);

  localparam logic [PCW-1:0] PIX_LAST  = PCW'(NPIX - 1);
  localparam logic [LNW-1:0] LANE_LAST = LNW'(PPW - 1);
  localparam logic [LVW-1:0] LVL_FULL  = LVW'(FIFO_DEPTH);

  logic [PCW-1:0]       pix_cnt;
  logic [LNW-1:0]       lane;
  logic [OUT_WIDTH-1:0] acc;

  logic [OUT_WIDTH-1:0] word;
  logic [PPW-1:0]       keep;
  logic                 last_px;
  logic                 word_done;

  logic [OUT_WIDTH-1:0] mem_data [FIFO_DEPTH];
  logic [PPW-1:0]       mem_keep [FIFO_DEPTH];
  logic                 mem_last [FIFO_DEPTH];

  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [LVW-1:0] level;

  logic empty;
  logic full;
  logic pop;
  logic push;
  logic drop;

  // Accumulator cleared after each word, so unused lanes of a
  // short final word are already zero.
  always_comb begin
    word = acc;
    word[int'(lane)*DATA_WIDTH +: DATA_WIDTH] = pixel_in;
    keep = '0;
    for (int i = 0; i < PPW; i++) begin
      keep[i] = (i <= int'(lane));
    end
    last_px   = (pix_cnt == PIX_LAST);
    word_done = pixel_in_valid &&
                ((lane == LANE_LAST) || last_px);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_cnt <= '0;
      lane    <= '0;
      acc     <= '0;
    end else if (pixel_in_valid) begin
      pix_cnt <= last_px ? '0 : pix_cnt + 1'b1;
      if (word_done) begin
        lane <= '0;
        acc  <= '0;
      end else begin
        lane <= lane + 1'b1;
        acc  <= word;
      end
    end
  end

  assign empty = (level == '0);
  assign full  = (level == LVL_FULL);
  assign pop   = !empty && m_tready;
  // A full FIFO still takes the word when the head leaves this cycle.
  assign push  = word_done && (!full || pop);
  assign drop  = word_done && full && !pop;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= word;
      mem_keep[wr_ptr] <= keep;
      mem_last[wr_ptr] <= last_px;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case (1'b1)
        (push && !pop): level <= level + 1'b1;
        (pop && !push): level <= level - 1'b1;
        default:        level <= level;
      endcase
    end
  end

  // Head is gated so the bus reads zero while nothing is buffered.
  assign m_tvalid   = !empty;
  assign m_tdata    = empty ? '0 : mem_data[rd_ptr];
  assign m_tkeep    = empty ? '0 : mem_keep[rd_ptr];
  assign m_tlast    = empty ? 1'b0 : mem_last[rd_ptr];
  assign fifo_level = level;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= pop && m_tlast;
      if (drop) begin
        overflow <= 1'b1;
      end else if (overflow_clr) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sobel_stream_packer.sv
// Bench for sobel_stream_packer: a 40-pixel/16-deep instance with a
// cycle-level scoreboard, and a 30-pixel/4-deep instance for tables.
module tb_sobel_stream_packer;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } word_t;

  typedef struct {
    int    ph;
    int    dut;
    int    idx;
    word_t w;
  } vec_t;

  int checks = 0;
  int failures = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        vin1 = 1'b0;
  logic [7:0]  pin1 = '0;
  logic        tready1 = 1'b1;
  logic        oclr1 = 1'b0;
  logic [31:0] td1;
  logic [3:0]  tk1;
  logic        tl1, tv1, fd1, ov1;
  logic [4:0]  lv1;

  logic        vin2 = 1'b0;
  logic [7:0]  pin2 = '0;
  logic        tready2 = 1'b1;
  logic        oclr2 = 1'b0;
  logic [31:0] td2;
  logic [3:0]  tk2;
  logic        tl2, tv2, fd2, ov2;
  logic [2:0]  lv2;

  always #5 clk = ~clk;

  sobel_stream_packer #(
    .DATA_WIDTH(8), .OUT_WIDTH(32), .IMG_WIDTH(10),
    .IMG_HEIGHT(4), .FIFO_DEPTH(16)
  ) u_dut1 (
    .clk(clk), .rst(rst),
    .pixel_in(pin1), .pixel_in_valid(vin1),
    .m_tdata(td1), .m_tkeep(tk1), .m_tlast(tl1),
    .m_tvalid(tv1), .m_tready(tready1),
    .fifo_level(lv1), .frame_done(fd1),
    .overflow(ov1), .overflow_clr(oclr1)
  );

  sobel_stream_packer #(
    .DATA_WIDTH(8), .OUT_WIDTH(32), .IMG_WIDTH(10),
    .IMG_HEIGHT(3), .FIFO_DEPTH(4)
  ) u_dut2 (
    .clk(clk), .rst(rst),
    .pixel_in(pin2), .pixel_in_valid(vin2),
    .m_tdata(td2), .m_tkeep(tk2), .m_tlast(tl2),
    .m_tvalid(tv2), .m_tready(tready2),
    .fifo_level(lv2), .frame_done(fd2),
    .overflow(ov2), .overflow_clr(oclr2)
  );

  task automatic check(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Scoreboard model of instance 1 (40 px/frame, 16 words deep).
  word_t mq[$];
  logic  m_ovf = 1'b0;
  logic  m_fd = 1'b0;
  int    mpix = 0;
  int    mlane = 0;
  logic [31:0] macc = '0;
  bit    chk1 = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_ovf = 1'b0;
      m_fd = 1'b0;
      mpix = 0;
      mlane = 0;
      macc = '0;
    end else begin : step
      bit    full, pop, set;
      word_t w;
      full = (mq.size() == 16);
      pop = (mq.size() > 0) && tready1;
      set = 1'b0;
      m_fd = 1'b0;
      if (pop) begin
        w = mq.pop_front();
        m_fd = w.l;
      end
      if (vin1) begin
        macc[mlane*8 +: 8] = pin1;
        if (mlane == 3 || mpix == 39) begin
          w.d = macc;
          w.k = 4'((1 << (mlane + 1)) - 1);
          w.l = (mpix == 39);
          if (!full || pop) mq.push_back(w);
          else begin
            m_ovf = 1'b1;
            set = 1'b1;
          end
          macc = '0;
          mlane = 0;
        end else begin
          mlane++;
        end
        mpix = (mpix == 39) ? 0 : mpix + 1;
      end
      if (oclr1 && !set) m_ovf = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (chk1 && !rst) begin
      check("d1_tvalid", tv1, mq.size() > 0);
      check("d1_level", lv1, mq.size());
      check("d1_overflow", ov1, m_ovf);
      check("d1_frame_done", fd1, m_fd);
      if (mq.size() > 0) check("d1_head", {td1, tk1, tl1}, mq[0]);
    end
  end

  // Handshake logs for table comparisons.
  word_t log1[$];
  word_t log2[$];
  int fd1_cnt = 0;
  int fd2_cnt = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (tv1 && tready1) log1.push_back({td1, tk1, tl1});
      if (tv2 && tready2) log2.push_back({td2, tk2, tl2});
      if (fd1) fd1_cnt++;
      if (fd2) fd2_cnt++;
    end
  end

  vec_t tbl[$];

  function automatic vec_t mk(input int ph, input int dut,
                              input int idx, input logic [31:0] d,
                              input logic [3:0] k, input logic l);
    vec_t v;
    v.ph = ph;
    v.dut = dut;
    v.idx = idx;
    v.w = {d, k, l};
    return v;
  endfunction

  task automatic check_phase(input int ph);
    word_t got;
    foreach (tbl[i]) begin
      if (tbl[i].ph == ph) begin
        got = 'x;
        if (tbl[i].dut == 1 && tbl[i].idx < log1.size())
          got = log1[tbl[i].idx];
        if (tbl[i].dut == 2 && tbl[i].idx < log2.size())
          got = log2[tbl[i].idx];
        check($sformatf("ph%0d_d%0d_w%0d", ph, tbl[i].dut, tbl[i].idx),
              got, tbl[i].w);
      end
    end
  endtask

  task automatic send1(input int n, input logic [7:0] base,
                       input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk); #1;
          vin1 = 1'b0;
        end
      end
      @(posedge clk); #1;
      vin1 = 1'b1;
      pin1 = base + 8'(i);
    end
    @(posedge clk); #1;
    vin1 = 1'b0;
  endtask

  task automatic send2(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      vin2 = 1'b1;
      pin2 = base + 8'(i);
    end
    @(posedge clk); #1;
    vin2 = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl.push_back(mk(1, 1, 0, 32'h03020100, 4'hF, 1'b0));
    tbl.push_back(mk(1, 1, 4, 32'h13121110, 4'hF, 1'b0));
    tbl.push_back(mk(1, 1, 8, 32'h23222120, 4'hF, 1'b0));
    tbl.push_back(mk(1, 1, 9, 32'h27262524, 4'hF, 1'b1));
    tbl.push_back(mk(2, 1, 0, 32'h43424140, 4'hF, 1'b0));
    tbl.push_back(mk(2, 1, 9, 32'h67666564, 4'hF, 1'b1));
    tbl.push_back(mk(3, 1, 0, 32'h83828180, 4'hF, 1'b0));
    tbl.push_back(mk(3, 1, 9, 32'hA7A6A5A4, 4'hF, 1'b1));
    tbl.push_back(mk(4, 1, 0, 32'hC3C2C1C0, 4'hF, 1'b0));
    tbl.push_back(mk(4, 1, 9, 32'hE7E6E5E4, 4'hF, 1'b1));
    tbl.push_back(mk(5, 2, 0, 32'h03020100, 4'hF, 1'b0));
    tbl.push_back(mk(5, 2, 6, 32'h1B1A1918, 4'hF, 1'b0));
    tbl.push_back(mk(5, 2, 7, 32'h00001D1C, 4'h3, 1'b1));
    tbl.push_back(mk(6, 2, 0, 32'h23222120, 4'hF, 1'b0));
    tbl.push_back(mk(6, 2, 4, 32'h33323130, 4'hF, 1'b0));
    tbl.push_back(mk(6, 2, 7, 32'h00003D3C, 4'h3, 1'b1));
    tbl.push_back(mk(7, 2, 0, 32'h43424140, 4'hF, 1'b0));
    tbl.push_back(mk(7, 2, 3, 32'h4F4E4D4C, 4'hF, 1'b0));
    tbl.push_back(mk(7, 2, 4, 32'h63626160, 4'hF, 1'b0));
    tbl.push_back(mk(7, 2, 10, 32'h7B7A7978, 4'hF, 1'b0));
    tbl.push_back(mk(7, 2, 11, 32'h00007D7C, 4'h3, 1'b1));

    // Reset values.
    cycles(2);
    check("rst_tvalid", tv1, 1'b0);
    check("rst_tdata", td1, 32'h0);
    check("rst_tkeep", tk1, 4'h0);
    check("rst_tlast", tl1, 1'b0);
    check("rst_level", lv1, 5'd0);
    check("rst_frame_done", fd1, 1'b0);
    check("rst_overflow", ov1, 1'b0);
    check("rst2_tvalid", tv2, 1'b0);
    check("rst2_level", lv2, 3'd0);
    rst = 1'b0;
    chk1 = 1'b1;

    // Full frame, always ready.
    log1.delete();
    fd1_cnt = 0;
    send1(40, 8'h00, 1'b0);
    cycles(5);
    check("ph1_words", log1.size(), 10);
    check("ph1_frame_done_cnt", fd1_cnt, 1);
    check("ph1_overflow", ov1, 1'b0);
    check_phase(1);

    // Random valid gaps.
    log1.delete();
    send1(40, 8'h40, 1'b1);
    cycles(5);
    check("ph2_words", log1.size(), 10);
    check_phase(2);

    // Whole frame stalled, then drained.
    log1.delete();
    tready1 = 1'b0;
    send1(40, 8'h80, 1'b0);
    cycles(3);
    check("ph3_level", lv1, 5'd10);
    check("ph3_head", td1, 32'h83828180);
    tready1 = 1'b1;
    cycles(14);
    check("ph3_words", log1.size(), 10);
    check_phase(3);

    // Short frame on the 30-pixel instance.
    log2.delete();
    fd2_cnt = 0;
    send2(30, 8'h00);
    cycles(10);
    check("ph5_words", log2.size(), 8);
    check_phase(5);

    // Completing pixel into a full FIFO while the head pops.
    log2.delete();
    tready2 = 1'b0;
    send2(16, 8'h20);
    check("ph6_full_level", lv2, 3'd4);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      vin2 = 1'b1;
      pin2 = 8'h30 + 8'(i);
    end
    @(posedge clk); #1;
    pin2 = 8'h33;
    tready2 = 1'b1;
    @(posedge clk); #1;
    vin2 = 1'b0;
    tready2 = 1'b0;
    check("ph6_level_same", lv2, 3'd4);
    check("ph6_no_overflow", ov2, 1'b0);
    check("ph6_head", td2, 32'h27262524);
    tready2 = 1'b1;
    send2(10, 8'h34);
    cycles(10);
    check("ph6_words", log2.size(), 8);
    check_phase(6);

    // Overflow on a 4-deep FIFO, then a clean frame and clear.
    log2.delete();
    tready2 = 1'b0;
    send2(30, 8'h40);
    check("ph7_level", lv2, 3'd4);
    check("ph7_overflow_set", ov2, 1'b1);
    tready2 = 1'b1;
    cycles(6);
    check("ph7_drained", log2.size(), 4);
    send2(30, 8'h60);
    cycles(10);
    check("ph7_words", log2.size(), 12);
    check_phase(7);
    check("ph7_overflow_sticky", ov2, 1'b1);
    @(posedge clk); #1;
    oclr2 = 1'b1;
    @(posedge clk); #1;
    oclr2 = 1'b0;
    check("ph7_overflow_clr", ov2, 1'b0);
    check("d2_frame_done_cnt", fd2_cnt, 3);

    // Reset mid-frame with words buffered.
    tready1 = 1'b0;
    send1(9, 8'h90, 1'b0);
    check("ph4_pre_level", lv1, 5'd2);
    rst = 1'b1;
    #1;
    check("ph4_rst_tvalid", tv1, 1'b0);
    check("ph4_rst_level", lv1, 5'd0);
    check("ph4_rst_tdata", td1, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    tready1 = 1'b1;
    log1.delete();
    send1(40, 8'hC0, 1'b0);
    cycles(5);
    check("ph4_words", log1.size(), 10);
    check_phase(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
